// File: rtl/uart_tx_queue.sv
// uart_tx_queue: host-side FIFO in front of a UART sender. Words are launched
// one at a time through send/send_data/sent, with an idle gap after each frame
// and a watchdog that abandons a frame whose sender never reports completion.
module uart_tx_queue #(
  parameter  int DEPTH      = 8,
  parameter  int GAP_CYCLES = 2,
  parameter  int TIMEOUT    = 4096,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int DATA_W     = 7
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              send,
  output logic [DATA_W-1:0] send_data,
  input  logic              sent,
  output logic              busy,
  output logic              tx_timeout
);

  // One counter serves both the completion watchdog and the idle gap.
  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES + 1;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sent_p1;
  logic              push, pop, load, done;

  // Writes are gated by the registered full flag, so a pop in the same cycle
  // never makes room for a write that arrives while full.
  assign push = wr_en && !full;
  assign pop  = (state == LAUNCH);
  // Rising edge of sent: accepts both single-cycle pulses and held levels.
  assign done = sent && !sent_p1;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (!push && pop)
      count_nxt = count - 1'b1;
  end

  // Storage array: data only, holds its contents across reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy, status flags and the overflow pulse.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      full     <= (count_nxt == FULL_CNT);
      empty    <= (count_nxt == '0);
      overflow <= wr_en && full;
    end
  end

  // FSM state, sent edge history, shared counter and the launched word.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      sent_p1   <= 1'b0;
      cnt       <= '0;
      send_data <= '0;
    end else begin
      state   <= state_nxt;
      sent_p1 <= sent;
      cnt     <= cnt_nxt;
      if (load)
        send_data <= mem[rd_ptr];
    end
  end

  // Next-state and outputs: launch, wait for completion or timeout, then gap.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load       = 1'b0;
    send       = 1'b0;
    busy       = 1'b1;
    tx_timeout = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!empty) begin
          state_nxt = LAUNCH;
          load      = 1'b1;
        end
      end
      LAUNCH: begin
        send      = 1'b1;
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        if (done) begin
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          tx_timeout = 1'b1;
          state_nxt  = (GAP_CYCLES > 0) ? GAP : IDLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
